// File: rtl/mem_port_arbiter_if.sv
// Bundle between the core stage sequencer, the shared memory port and the arbiter.
// The arbiter takes the slave view; the environment (core plus memory) takes the master view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_done;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_done;

    logic              xfer_err;
    logic              busy;
    logic              grant_dm;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        input  mem_ack, mem_rdata,
        output if_rdata, if_done,
        output dm_rdata, dm_done,
        output xfer_err, busy, grant_dm,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr,
        output dm_req, dm_we, dm_addr, dm_wdata,
        output mem_ack, mem_rdata,
        input  if_rdata, if_done,
        input  dm_rdata, dm_done,
        input  xfer_err, busy, grant_dm,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data access,
// with a variable-latency ack handshake and an optional BUSY-phase timeout.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                reset_n,
    mem_port_arbiter_if.slave   bus
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;
    localparam bit TO_EN = (TIMEOUT_CYC != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_last_grant;
    logic [CNT_W-1:0]  r_cnt;

    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;
    logic              r_if_done;
    logic              r_dm_done;
    logic              r_xfer_err;
    logic              r_busy;
    logic              r_grant_dm;

    logic              w_any_req;
    logic              w_pick_dm;
    logic              w_timeout;

    assign w_any_req = bus.if_req | bus.dm_req;
    // DM wins when alone, or on contention when IF was served last.
    assign w_pick_dm = bus.dm_req & (~bus.if_req | ~r_last_grant);
    assign w_timeout = TO_EN && (r_cnt == TO_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b0;
            r_cnt        <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_if_rdata   <= '0;
            r_dm_rdata   <= '0;
            r_if_done    <= 1'b0;
            r_dm_done    <= 1'b0;
            r_xfer_err   <= 1'b0;
            r_busy       <= 1'b0;
            r_grant_dm   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_mem_req    <= 1'b1;
                        r_grant_dm   <= w_pick_dm;
                        r_last_grant <= w_pick_dm;
                        r_mem_addr   <= w_pick_dm ? bus.dm_addr : bus.if_addr;
                        r_mem_we     <= w_pick_dm & bus.dm_we;
                        r_mem_wdata  <= w_pick_dm ? bus.dm_wdata : '0;
                        r_busy       <= 1'b1;
                        r_cnt        <= '0;
                        r_state      <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (bus.mem_ack) begin
                        r_mem_req  <= 1'b0;
                        r_if_done  <= ~r_grant_dm;
                        r_dm_done  <= r_grant_dm;
                        r_xfer_err <= 1'b0;
                        if (!r_mem_we) begin
                            if (r_grant_dm) begin
                                r_dm_rdata <= bus.mem_rdata;
                            end else begin
                                r_if_rdata <= bus.mem_rdata;
                            end
                        end
                        r_state <= S_DONE;
                    end else if (w_timeout) begin
                        // Aborted read returns zero so stale data is never mistaken for a result.
                        r_mem_req  <= 1'b0;
                        r_if_done  <= ~r_grant_dm;
                        r_dm_done  <= r_grant_dm;
                        r_xfer_err <= 1'b1;
                        if (!r_mem_we) begin
                            if (r_grant_dm) begin
                                r_dm_rdata <= '0;
                            end else begin
                                r_if_rdata <= '0;
                            end
                        end
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_if_done  <= 1'b0;
                    r_dm_done  <= 1'b0;
                    r_xfer_err <= 1'b0;
                    r_busy     <= 1'b0;
                    r_cnt      <= '0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.dm_rdata  = r_dm_rdata;
    assign bus.if_done   = r_if_done;
    assign bus.dm_done   = r_dm_done;
    assign bus.xfer_err  = r_xfer_err;
    assign bus.busy      = r_busy;
    assign bus.grant_dm  = r_grant_dm;

endmodule
